// File: rtl/envelope_decimator.sv
// Block-averaging decimator for the envelope stream: every DECIM accepted
// samples are summed, truncated to their mean and queued in a small FWFT FIFO.
module envelope_decimator #(
  parameter int DECIM      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [31:0]                   in_data,
  input  logic                          in_valid,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int LOG_D = $clog2(DECIM);
  localparam int AW    = 32 + LOG_D;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  logic [AW-1:0] acc;
  logic [LOG_D-1:0] cnt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [AW-1:0] sum;
  logic [31:0] avg;
  logic window_done;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake: the input side has no ready; a sample is taken on every edge
  // with in_valid high. The output side pops the head on every edge where
  // out_valid && out_ready; out_valid depends only on registered occupancy.
  always_comb begin
    sum         = acc + {{LOG_D{1'b0}}, in_data};
    avg         = sum[AW-1:LOG_D];
    window_done = in_valid && (cnt == LOG_D'(DECIM - 1));
    full        = (count == CW'(FIFO_DEPTH));
    pop         = (count != '0) && out_ready;
    // A full FIFO still accepts a new average when the head leaves on the same edge.
    push        = window_done && (!full || pop);
    drop        = window_done && full && !pop;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc      <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (in_valid) begin
        if (window_done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LOG_D'(1);
        end
      end
      if (push) begin
        mem[wr_ptr] <= avg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_data   = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_envelope_decimator.sv
// Directed bench for envelope_decimator (DECIM=4, FIFO_DEPTH=4) with a
// queue-based reference model checked every cycle plus literal spot checks.
module tb_envelope_decimator;

  localparam int DECIM      = 4;
  localparam int FIFO_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  envelope_decimator #(.DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model: a window sum and the expected FIFO contents
  logic [31:0]     exp_q[$];
  longint unsigned win_sum = 0;
  int              win_n = 0;
  bit              m_ovf = 0;
  bit              started = 0;

  always @(posedge CLK) begin
    bit          m_pop;
    logic [31:0] avg;
    if (RST) begin
      exp_q.delete();
      win_sum = 0;
      win_n   = 0;
      m_ovf   = 0;
      started = 1;
    end else begin
      m_pop = (exp_q.size() != 0) && out_ready;
      if (in_valid) begin
        win_sum += longint'(in_data);
        win_n++;
      end
      if (win_n == DECIM) begin
        avg = 32'(win_sum / DECIM);
        win_sum = 0;
        win_n   = 0;
        if (exp_q.size() < FIFO_DEPTH || m_pop) exp_q.push_back(avg);
        else m_ovf = 1;
      end
      if (m_pop) void'(exp_q.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge CLK) begin
    if (started && !RST) begin
      check("model_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("model_count", 32'(fifo_count), 32'(exp_q.size()));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      if (exp_q.size() != 0) check("model_data", out_data, exp_q[0]);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] w;
    tick();
    do_reset();
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // basic average, one-cycle latency, single-cycle valid
    out_ready = 1'b1;
    send(32'h1000); send(32'h2000); send(32'h3000); send(32'h4000);
    check("avg_valid", 32'(out_valid), 32'd1);
    check("avg_data", out_data, 32'h2800);
    tick();
    check("avg_valid_one_cycle", 32'(out_valid), 32'd0);

    // truncation and full-scale inputs
    send(32'd1); send(32'd1); send(32'd1); send(32'd2);
    check("trunc_data", out_data, 32'd1);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
    check("fullscale_data", out_data, 32'hFFFF_FFFF);
    tick();

    // overflow: five averages into a four-entry FIFO with no consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      for (int s = 0; s < 4; s++) send(32'h10 * k);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_order", out_data, 32'h10 * i);
      tick();
    end
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // push and pop on the same edge with a full FIFO
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      for (int s = 0; s < 4; s++) send(32'h100 * k);
    send(32'h500); send(32'h500); send(32'h500);
    out_ready = 1'b1;
    send(32'h500);
    out_ready = 1'b0;
    check("fullpp_count", 32'(fifo_count), 32'd4);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("fullpp_order", out_data, 32'h100 * i);
      tick();
    end
    check("fullpp_drained", 32'(fifo_count), 32'd0);

    // sparse strobes: every third cycle
    for (int n = 1; n <= 8; n++) begin
      send(32'h100);
      if (n % 4 == 0) begin
        check("sparse_valid", 32'(out_valid), 32'd1);
        check("sparse_data", out_data, 32'h100);
      end
      idle(2);
    end

    // reset in the middle of a window with entries queued
    out_ready = 1'b0;
    for (int s = 0; s < 8; s++) send(32'h20);
    send(32'h20); send(32'h20);
    check("mid_count_before", 32'(fifo_count), 32'd2);
    RST = 1'b1; in_valid = 1'b1; in_data = 32'h20; out_ready = 1'b1;
    tick();
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    for (int s = 0; s < 4; s++) send(32'h8);
    w = out_data;
    check("mid_new_window", w, 32'h8);
    check("mid_new_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_decimator.md
ENVELOPE_DECIMATOR -- requirements
Module: envelope_decimator

Interface
REQ-001 Parameter DECIM, default 16: input samples averaged per output sample; power of two, 2..256.
REQ-002 Parameter FIFO_DEPTH, default 8: output FIFO entries; power of two, 2..64.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  32  unsigned fixed-point envelope sample from the homomorphic envelope stage output_data.
REQ-006 in_valid  input  1  sample strobe, driven by that stage's write_enable; in_data accepted on every edge where high.
REQ-007 out_data  output  32  averaged sample at FIFO head, same fixed-point format as in_data.
REQ-008 out_valid  output  1  FIFO non-empty; out_data valid.
REQ-009 out_ready  input  1  consumer accepts head; pop on edge with out_valid&&out_ready.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky flag: an average was dropped.

Function
REQ-012 No backpressure on input: block always accepts in_valid samples.
REQ-013 Accumulator width 32+log2(DECIM), unsigned; sample counter width log2(DECIM).
REQ-014 Each accepted sample: counter increments; sample added to accumulator.
REQ-015 On accepting sample DECIM (counter==DECIM-1): average = (acc+in_data)>>log2(DECIM), truncated, not rounded; pushed to FIFO same edge; accumulator and counter cleared same edge.
REQ-016 Latency: average visible on out_data/out_valid in cycle immediately after the edge accepting sample DECIM (one cycle), FIFO previously empty.
REQ-017 FIFO first-word-fall-through: out_data = head entry; out_data holds last popped value's slot content irrelevant when out_valid low, but SHALL not be X after reset (reads 0).
REQ-018 out_valid = (fifo_count!=0), registered-state derived, no combinational path from out_ready.
REQ-019 Push when full and no pop same edge: average dropped, FIFO unchanged, overflow set to 1.
REQ-020 Push and pop same edge when full: both occur, count unchanged, no drop, overflow unchanged.
REQ-021 Push and pop same edge when count in 1..FIFO_DEPTH-1: count unchanged, order preserved.
REQ-022 Pop when empty (out_ready high, out_valid low): no effect.
REQ-023 Read/write pointers wrap modulo FIFO_DEPTH; FIFO strictly in-order.
REQ-024 in_valid low: accumulator, counter hold; partial windows persist indefinitely.
REQ-025 overflow cleared only by RST.

Reset
REQ-026 RST high at edge: accumulator=0, counter=0, pointers=0, fifo_count=0, out_valid=0, out_data=0, overflow=0.
REQ-027 RST dominates in_valid and out_ready same edge; sample in flight and partial window discarded, FIFO contents discarded.
REQ-028 First sample after RST release starts new window at count 0.

Verification (DECIM=4, FIFO_DEPTH=4 unless stated)
REQ-029 Samples 0x1000,0x2000,0x3000,0x4000 back-to-back, out_ready=1 -> out_data=0x2800, out_valid high exactly one cycle, one cycle after 4th sample.
REQ-030 Samples 1,1,1,2 -> out_data=1 (truncation); samples 0xFFFFFFFF x4 -> out_data=0xFFFFFFFF (no accumulator overflow).
REQ-031 out_ready=0, 20 samples of value 0x10*k-window -> 5 averages produced, first 4 stored, 5th dropped, fifo_count=4, overflow=1; then out_ready=1 -> 4 pops in order, count 0, overflow stays 1.
REQ-032 FIFO full, 4th sample of next window arrives same edge as pop -> count stays 4, no drop, overflow=0, new average at tail.
REQ-033 in_valid strobed every 3rd cycle with 0x100 -> output 0x100 one cycle after every 4th strobe; gaps do not disturb windows.
REQ-034 Assert RST after 2 samples of a window with 2 entries queued -> next cycle fifo_count=0, out_valid=0, overflow=0; next 4 samples 0x8 -> out_data=0x8.
